// File: rtl/if_redirect_fetch_pkg.sv
// Shared fetch-stage constants, the queued entry layout and a small alignment helper.
package if_redirect_fetch_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned INST_W = 32;

    localparam logic [XLEN-1:0] PC_STEP          = 64'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

    // One instruction handed to ID, tagged with the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_sync_fifo.sv
// Small synchronous FIFO with occupancy count and a single-cycle clear.
module if_sync_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    // Control state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage write; contents need no reset since the count gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/if_redirect_fetch.sv
// Fetch stage: owns the PC, issues in-order fetches, pairs responses with their PCs and
// queues them for ID. A redirect retargets the PC, flushes the queue and arms a drop count
// that swallows every response still in flight from the old stream.
module if_redirect_fetch
    import if_redirect_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned MAX_OUTSTD = 4,
    parameter int unsigned OUTQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_e,
    input  logic [63:0] br_addr,
    output logic        inst_req_valid,
    input  logic        inst_req_ready,
    output logic [63:0] inst_req_addr,
    input  logic        inst_resp_valid,
    input  logic [31:0] inst_resp_data,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_flush
);

    localparam int unsigned OS_W = $clog2(MAX_OUTSTD + 1);
    localparam int unsigned OQ_W = $clog2(OUTQ_DEPTH + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [OS_W-1:0] outstd_q, outstd_d;
    logic [OS_W-1:0] drop_q, drop_d;

    logic            req_fire;
    logic            resp_fire;
    int unsigned     live_cnt;

    logic [XLEN-1:0] pcf_head;
    logic            pcf_full, pcf_empty;
    logic [OS_W-1:0] pcf_count;

    logic            outq_push, outq_pop;
    fetch_entry_t    outq_in, outq_head;
    logic            outq_full, outq_empty;
    logic [OQ_W-1:0] outq_count;

    // Responses with nothing outstanding (e.g. stragglers across a reset) are ignored.
    assign resp_fire = inst_resp_valid && (outstd_q != '0) && !rst;
    assign req_fire  = inst_req_valid && inst_req_ready;

    // Instructions that will still land in the queue: live in-flight plus already queued.
    assign live_cnt = 32'(outstd_q) - 32'(drop_q) + 32'(outq_count);

    assign inst_req_addr  = pc_q;
    assign inst_req_valid = !rst && !br_e && (32'(outstd_q) < MAX_OUTSTD)
                            && (live_cnt < OUTQ_DEPTH);

    assign if_flush  = br_e;
    assign outq_push = resp_fire && !br_e && (drop_q == '0);
    assign outq_pop  = if_valid && id_ready && !br_e;
    assign outq_in   = '{pc: pcf_head, inst: inst_resp_data};

    assign if_valid = !outq_empty;
    assign if_pc    = if_valid ? outq_head.pc : '0;
    assign if_inst  = if_valid ? outq_head.inst : '0;

    // PCs of issued-but-unreturned fetches, popped in order as responses arrive.
    if_sync_fifo #(
        .DEPTH (MAX_OUTSTD),
        .WIDTH (XLEN)
    ) u_pc_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (1'b0),
        .push_i  (req_fire),
        .data_i  (pc_q),
        .pop_i   (resp_fire),
        .data_o  (pcf_head),
        .full_o  (pcf_full),
        .empty_o (pcf_empty),
        .count_o (pcf_count)
    );

    // Registered hand-off queue toward ID; a redirect empties it in one cycle.
    if_sync_fifo #(
        .DEPTH (OUTQ_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_out_queue (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (br_e),
        .push_i  (outq_push),
        .data_i  (outq_in),
        .pop_i   (outq_pop),
        .data_o  (outq_head),
        .full_o  (outq_full),
        .empty_o (outq_empty),
        .count_o (outq_count)
    );

    // PC, outstanding and drop-count next-state; redirect overrides normal stepping.
    always_comb begin
        pc_d     = pc_q;
        outstd_d = outstd_q + OS_W'(req_fire) - OS_W'(resp_fire);
        drop_d   = drop_q;
        if (br_e) begin
            pc_d   = align_word(br_addr);
            // Everything still in flight after this edge belongs to the old stream.
            drop_d = outstd_q - OS_W'(resp_fire);
        end else begin
            if (req_fire) pc_d = pc_q + PC_STEP;
            if (resp_fire && (drop_q != '0)) drop_d = drop_q - OS_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            outstd_q <= '0;
            drop_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            outstd_q <= outstd_d;
            drop_q   <= drop_d;
        end
    end

    // Protocol and bookkeeping sanity checks for simulation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(inst_resp_valid && outstd_q == '0));
            assert (pcf_count == outstd_q);
            assert (!(resp_fire && pcf_empty));
            assert (!(req_fire && pcf_full));
            assert (!(outq_push && outq_full && !outq_pop));
            assert (drop_q <= outstd_q);
        end
    end

endmodule

// File: tb/tb_if_redirect_fetch.sv
// Randomized bench: a latency-randomised in-order memory plus a stream-level reference model
// (expected request PC, expected next PC delivered to ID, and a redirect epoch per request).
module tb_if_redirect_fetch;

    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam int unsigned MAX_OS = 4;
    localparam int unsigned OQ_D   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_e = 1'b0;
    logic [63:0] br_addr = '0;
    logic        inst_req_valid;
    logic        inst_req_ready = 1'b0;
    logic [63:0] inst_req_addr;
    logic        inst_resp_valid = 1'b0;
    logic [31:0] inst_resp_data = '0;
    logic        if_valid;
    logic        id_ready = 1'b0;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic        if_flush;

    always #5 clk = ~clk;

    if_redirect_fetch #(
        .RESET_PC   (RST_PC),
        .MAX_OUTSTD (MAX_OS),
        .OUTQ_DEPTH (OQ_D)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .br_e            (br_e),
        .br_addr         (br_addr),
        .inst_req_valid  (inst_req_valid),
        .inst_req_ready  (inst_req_ready),
        .inst_req_addr   (inst_req_addr),
        .inst_resp_valid (inst_resp_valid),
        .inst_resp_data  (inst_resp_data),
        .if_valid        (if_valid),
        .id_ready        (id_ready),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .if_flush        (if_flush)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Memory contents: a fixed function of the address.
    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
    endfunction

    // Reference model state.
    logic [63:0] exp_req_pc = RST_PC;
    logic [63:0] exp_id_pc  = RST_PC;
    logic [63:0] addr_q[$];
    int          due_q[$];
    int          ep_q[$];
    int          cur_ep = 0;
    int          cyc = 0;
    int          consumed = 0;

    bit          prev_req_wait = 0;
    bit          prev_hold = 0;
    bit          prev_br = 0;
    bit          prev_rst = 0;
    bit          prev_live_resp = 0;
    logic [63:0] prev_pc;
    logic [31:0] prev_inst;

    task automatic run_cycles(input int n, input int p_br, input int p_rst, input int p_idr,
                              input int p_rdy, input int p_resp, input int lat_max,
                              input bit chk_stall);
        for (int i = 0; i < n; i++) begin
            bit do_rst, do_br, fire, live_resp;
            @(negedge clk);
            cyc++;
            do_rst = ($urandom_range(0, 999) < 32'(p_rst * 10));
            do_br  = !do_rst && ($urandom_range(0, 99) < 32'(p_br));
            rst    = do_rst;
            br_e   = do_br;
            br_addr = {32'h0, 32'h8000_0000 | ($urandom & 32'h000f_ffff)};
            id_ready       = ($urandom_range(0, 99) < 32'(p_idr));
            inst_req_ready = ($urandom_range(0, 99) < 32'(p_rdy));
            inst_resp_valid = !do_rst && (addr_q.size() > 0) && (due_q[0] <= cyc)
                              && ($urandom_range(0, 99) < 32'(p_resp));
            inst_resp_data  = inst_resp_valid ? inst_of(addr_q[0]) : $urandom;
            #1;

            check_eq("flush_eq_br", {63'd0, if_flush}, {63'd0, br_e});
            if (do_rst || do_br)
                check_eq("req_blocked", {63'd0, inst_req_valid}, 64'd0);
            else if (prev_req_wait)
                check_eq("req_valid_hold", {63'd0, inst_req_valid}, 64'd1);
            if (inst_req_valid) begin
                check_eq("req_addr", inst_req_addr, exp_req_pc);
                check_eq("outstd_bound", {63'd0, addr_q.size() < MAX_OS}, 64'd1);
            end
            if (prev_rst) begin
                check_eq("rst_if_valid", {63'd0, if_valid}, 64'd0);
                check_eq("rst_if_pc", if_pc, 64'd0);
                check_eq("rst_if_inst", {32'd0, if_inst}, 64'd0);
                check_eq("rst_req_addr", inst_req_addr, RST_PC);
            end
            if (prev_br) check_eq("flush_empties_q", {63'd0, if_valid}, 64'd0);
            if (prev_live_resp) check_eq("resp_latency", {63'd0, if_valid}, 64'd1);
            if (prev_hold) begin
                check_eq("hold_valid", {63'd0, if_valid}, 64'd1);
                check_eq("hold_pc", if_pc, prev_pc);
                check_eq("hold_inst", {32'd0, if_inst}, {32'd0, prev_inst});
            end
            if (!do_rst && !do_br && if_valid && id_ready) begin
                check_eq("id_pc", if_pc, exp_id_pc);
                check_eq("id_inst", {32'd0, if_inst}, {32'd0, inst_of(if_pc)});
                exp_id_pc = exp_id_pc + 64'd4;
                consumed++;
            end
            if (chk_stall && i == n - 1) begin
                check_eq("stall_req_valid", {63'd0, inst_req_valid}, 64'd0);
                check_eq("stall_if_valid", {63'd0, if_valid}, 64'd1);
                check_eq("stall_if_pc", if_pc, exp_id_pc);
                check_eq("stall_queued", exp_req_pc - exp_id_pc, 64'(OQ_D * 4));
            end

            // Advance the model as of the coming rising edge.
            fire = inst_req_valid && inst_req_ready;
            live_resp = 1'b0;
            if (inst_resp_valid) begin
                live_resp = !do_br && (ep_q[0] == cur_ep);
                void'(addr_q.pop_front());
                void'(due_q.pop_front());
                void'(ep_q.pop_front());
            end
            if (fire) begin
                addr_q.push_back(inst_req_addr);
                due_q.push_back(cyc + int'($urandom_range(1, lat_max)));
                ep_q.push_back(cur_ep);
                exp_req_pc = exp_req_pc + 64'd4;
            end
            if (do_br) begin
                cur_ep++;
                exp_req_pc = {br_addr[63:2], 2'b00};
                exp_id_pc  = {br_addr[63:2], 2'b00};
            end
            if (do_rst) begin
                addr_q.delete();
                due_q.delete();
                ep_q.delete();
                cur_ep++;
                exp_req_pc = RST_PC;
                exp_id_pc  = RST_PC;
            end
            prev_req_wait  = inst_req_valid && !inst_req_ready;
            prev_hold      = if_valid && !id_ready && !do_br && !do_rst;
            prev_pc        = if_pc;
            prev_inst      = if_inst;
            prev_br        = do_br;
            prev_rst       = do_rst;
            prev_live_resp = live_resp;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("reset_req_valid", {63'd0, inst_req_valid}, 64'd0);
        check_eq("reset_req_addr", inst_req_addr, RST_PC);
        check_eq("reset_if_valid", {63'd0, if_valid}, 64'd0);
        check_eq("reset_if_pc", if_pc, 64'd0);
        check_eq("reset_if_inst", {32'd0, if_inst}, 64'd0);
        check_eq("reset_flush", {63'd0, if_flush}, 64'd0);
        @(posedge clk);

        //           n    br rst idr rdy resp lat stall
        run_cycles(40,    0, 0, 100, 100, 100, 1, 1'b0); // straight-line, 1-cycle memory
        run_cycles(30,    0, 0,   0, 100, 100, 3, 1'b1); // ID stalled: queue fills
        run_cycles(20,    0, 0, 100, 100, 100, 2, 1'b0); // release
        run_cycles(400,   4, 0,  70,  70,  70, 3, 1'b0); // occasional redirects
        run_cycles(300,  25, 0,  50,  80,  80, 3, 1'b0); // dense / back-to-back redirects
        run_cycles(400,   5, 1,  60,  60,  60, 4, 1'b0); // redirects plus mid-stream resets
        run_cycles(40,    0, 0, 100, 100, 100, 1, 1'b0);

        check_eq("progress", {63'd0, consumed > 100}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
